// File: rtl/score_display_ctrl.sv
// ---------------------------------------------------------------------------
// score_display_ctrl
// Multi-digit BCD score counter with saturation/overflow and a time-
// multiplexed, active-low 7-segment display driver with leading-zero
// blanking. Optional high-score register behind macro SCORE_HISCORE_EN.
//
// Parameters:
//   NUM_DIGITS  BCD digits counted and displayed (1..8)
//   SCAN_DIV    clk cycles each digit stays selected (>= 2)
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   score      score event, counted when ld is also high
//   ld         count enable
//   clr        synchronous clear of score and overflow (wins over counting)
//   show_hi    display the high score (SCORE_HISCORE_EN only)
//   score_bcd  current score, digit 0 in bits [3:0]
//   overflow   sticky, set on an increment attempted at all-9s
//   seg        {A,B,C,D,E,F,G}, active-low
//   AN         digit anodes, active-low one-hot
// ---------------------------------------------------------------------------
module score_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    score,
    input  logic                    ld,
    input  logic                    clr,
    input  logic                    show_hi,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic                    overflow,
    output logic [6:0]              seg,
    output logic [7:0]              AN
);

    localparam int unsigned BW = 4 * NUM_DIGITS;
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [BW-1:0] inc_val;
    logic          all_nines;
    logic [BW-1:0] disp_val;
    logic [PW-1:0] prescale;
    logic [IW-1:0] scan_idx;
    logic [3:0]    cur_digit;
    logic          cur_blank;
    logic [7:0]    an_next;

    // Active-low segment pattern for one BCD code
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // BCD +1 with ripple carry; all_nines marks the saturation point
    always_comb begin
        logic carry;
        inc_val   = score_bcd;
        all_nines = 1'b1;
        carry     = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (score_bcd[4*i +: 4] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (score_bcd[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Score and sticky overflow; clr beats any same-cycle increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_bcd <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            score_bcd <= '0;
            overflow  <= 1'b0;
        end else if (score && ld) begin
            if (all_nines) begin
                overflow <= 1'b1;
            end else begin
                score_bcd <= inc_val;
            end
        end
    end

`ifdef SCORE_HISCORE_EN
    logic [BW-1:0] hi_bcd;

    // Nibble-wise BCD ordering matches plain unsigned ordering of the vector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_bcd <= '0;
        end else if (clr && (score_bcd > hi_bcd)) begin
            hi_bcd <= score_bcd;
        end
    end

    assign disp_val = show_hi ? hi_bcd : score_bcd;
`else
    logic unused_show_hi;
    assign unused_show_hi = show_hi;
    assign disp_val       = score_bcd;
`endif

    // Prescaler and scan index; index wraps at NUM_DIGITS-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= '0;
            scan_idx <= '0;
        end else if (prescale == PRE_LAST) begin
            prescale <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    // Select the scanned digit; blank it when it and all digits above are zero
    always_comb begin
        logic zero_from_top;
        cur_digit     = 4'd0;
        cur_blank     = 1'b0;
        an_next       = 8'hFF;
        zero_from_top = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_from_top = zero_from_top && (disp_val[4*i +: 4] == 4'd0);
            if (IW'(i) == scan_idx) begin
                cur_digit  = disp_val[4*i +: 4];
                cur_blank  = (i != 0) && zero_from_top;
                an_next[i] = 1'b0;
            end
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            AN  <= 8'hFF;
            seg <= 7'b1111111;
        end else begin
            AN  <= an_next;
            seg <= cur_blank ? 7'b1111111 : seg_decode(cur_digit);
        end
    end

endmodule
